// File: rtl/fp8_pkg.sv
// Shared field layout, normalisation encodings and FSM states for the 8-bit FP add/sub unit.
package fp8_pkg;
   localparam int EXP_W    = 3;
   localparam int MANT_W   = 4;
   localparam int SIGN_BIT = 7;
   localparam int EXP_MSB  = 6;
   localparam int EXP_LSB  = 4;

   localparam logic [1:0] NORM_NONE = 2'b00;
   localparam logic [1:0] NORM_ADD  = 2'b01;
   localparam logic [1:0] NORM_SUB  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ALIGN, ST_CAPTURE, ST_NORM, ST_DONE
   } state_t;
endpackage

// File: rtl/fp_exp_norm.sv
// NORM-stage exponent adjust and result packing.
// FP_ADDSUB_SAT_EN: saturate to max magnitude on overflow instead of wrapping the exponent.
module fp_exp_norm
   import fp8_pkg::*;
(
   input  logic [EXP_W-1:0]         big_exp,
   input  logic [EXP_W-1:0]         norm,
   input  logic [1:0]               norm_sign,
   input  logic                     zero,
   input  logic                     sign_y,
   input  logic [MANT_W-1:0]        mant_y,
   output logic [EXP_W+MANT_W:0]    y,
   output logic                     overflow,
   output logic                     underflow
);
   // Two guard bits: one for carry past the field, one as the sign.
   logic [EXP_W+1:0] e;

   always_comb begin
      e = {2'b00, big_exp};
      case (norm_sign)
         NORM_ADD: e = {2'b00, big_exp} + {2'b00, norm};
         NORM_SUB: e = {2'b00, big_exp} - {2'b00, norm};
         default:  e = {2'b00, big_exp};
      endcase
   end

   always_comb begin
      overflow  = !zero && !e[EXP_W+1] && e[EXP_W];
      underflow = !zero && e[EXP_W+1];
      y         = {sign_y, e[EXP_W-1:0], mant_y};
      if (zero || underflow) begin
         y = '0;
      end else if (overflow) begin
`ifdef FP_ADDSUB_SAT_EN
         y = {sign_y, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
`else
         y = {sign_y, e[EXP_W-1:0], mant_y};
`endif
      end
   end
endmodule

// File: rtl/fp_addsub_ctrl.sv
// Exponent/control front-end for the 8-bit FP add/sub: operand handshake, datapath drive,
// result capture and exponent normalisation. Optional macro FP_ADDSUB_SAT_EN (see fp_exp_norm).
module fp_addsub_ctrl
   import fp8_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIGN_BIT:0]        A,
   input  logic [SIGN_BIT:0]        B,
   input  logic                     funct,
   output logic [SIGN_BIT:0]        dp_A,
   output logic [SIGN_BIT:0]        dp_B,
   output logic                     dp_funct,
   output logic [EXP_W:0]           dp_exp_diff,
   input  logic                     dp_zero,
   input  logic                     dp_sign_Y,
   input  logic [MANT_W-1:0]        dp_mant_Y,
   input  logic [EXP_W-1:0]         dp_exp_diff_norm,
   input  logic [1:0]               dp_exp_diff_sign,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIGN_BIT:0]        Y,
   output logic                     overflow,
   output logic                     underflow
);
   state_t state_q, state_d;

   logic              zero_q, sign_q;
   logic [MANT_W-1:0] mant_q;
   logic [EXP_W-1:0]  norm_q, big_exp_q;
   logic [1:0]        nsign_q;
   logic [SIGN_BIT:0] norm_y;
   logic              norm_ov, norm_uf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_ALIGN;
         end
         ST_ALIGN:   state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_NORM;
         ST_NORM:    state_d = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_A        <= '0;
         dp_B        <= '0;
         dp_funct    <= 1'b0;
         dp_exp_diff <= '0;
      end else if (state_q == ST_IDLE && in_valid) begin
         dp_A        <= A;
         dp_B        <= B;
         dp_funct    <= funct;
         dp_exp_diff <= {1'b0, A[EXP_MSB:EXP_LSB]} - {1'b0, B[EXP_MSB:EXP_LSB]};
      end
   end

   // Equal exponents give a non-negative difference and so select exp_A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q    <= 1'b0;
         sign_q    <= 1'b0;
         mant_q    <= '0;
         norm_q    <= '0;
         nsign_q   <= NORM_NONE;
         big_exp_q <= '0;
      end else if (state_q == ST_CAPTURE) begin
         zero_q    <= dp_zero;
         sign_q    <= dp_sign_Y;
         mant_q    <= dp_mant_Y;
         norm_q    <= dp_exp_diff_norm;
         nsign_q   <= dp_exp_diff_sign;
         big_exp_q <= dp_exp_diff[EXP_W] ? dp_B[EXP_MSB:EXP_LSB] : dp_A[EXP_MSB:EXP_LSB];
      end
   end

   fp_exp_norm u_norm (
      .big_exp   (big_exp_q),
      .norm      (norm_q),
      .norm_sign (nsign_q),
      .zero      (zero_q),
      .sign_y    (sign_q),
      .mant_y    (mant_q),
      .y         (norm_y),
      .overflow  (norm_ov),
      .underflow (norm_uf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Y         <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (state_q == ST_NORM) begin
         Y         <= norm_y;
         overflow  <= norm_ov;
         underflow <= norm_uf;
      end
   end
endmodule

// File: doc/fp_addsub_ctrl.md
Name: fp_addsub_ctrl

Overview:
- Sequential exponent/control front-end for the 8-bit floating-point add/sub unit.
- Accepts operands A, B and funct on a valid/ready handshake, then computes and drives exp_diff plus the registered operands into the mantissa datapath.
- Captures the datapath results (zero, sign_Y, mant_Y, exp_diff_norm, exp_diff_sign) and applies exponent normalisation.
- Returns the packed result Y on a valid/ready handshake.
- Operand format: [7] sign, [6:4] exponent (unsigned), [3:0] mantissa (hidden leading 1).

Parameters:
- EXP_W, 3, exponent field width
- MANT_W, 4, mantissa field width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  high only in IDLE
- A  input  8  operand A
- B  input  8  operand B
- funct  input  1  0 = add, 1 = subtract (A-B)
- dp_A  output  8  registered A to datapath
- dp_B  output  8  registered B to datapath
- dp_funct  output  1  registered funct
- dp_exp_diff  output  4  exp_A-exp_B, 4-bit two's complement
- dp_zero  input  1  datapath zero result
- dp_sign_Y  input  1  datapath result sign
- dp_mant_Y  input  4  normalised mantissa
- dp_exp_diff_norm  input  3  exponent adjustment magnitude
- dp_exp_diff_sign  input  2  00 none, 01 add, 10 subtract, 11 treated as none
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Y  output  8  packed result
- overflow  output  1  exponent exceeded 7 (valid with out_valid)
- underflow  output  1  exponent below 0 (valid with out_valid)

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; Y, dp_A, dp_B, dp_exp_diff=0; dp_funct, overflow, underflow=0. Any operation in flight is discarded.
- FSM states: IDLE, ALIGN, CAPTURE, NORM, DONE.
- IDLE: in_ready=1. On in_valid, register A, B, funct, and dp_exp_diff = {1'b0,exp_A} - {1'b0,exp_B} (4-bit, wraps). Next state ALIGN.
- ALIGN: datapath inputs held stable for one full cycle (combinational settle). Next state CAPTURE.
- CAPTURE: register all five dp_* inputs. big_exp = dp_exp_diff[3] ? exp_B : exp_A (equal exponents select exp_A). Next state NORM.
- NORM: compute exponent as a signed 5-bit value e = big_exp + norm (sign 01), big_exp - norm (sign 10), otherwise big_exp. Build Y, overflow, underflow. Next state DONE.
  - Captured zero=1: Y=8'h00, overflow=0, underflow=0 (zero takes priority).
  - e>7: overflow=1.
  - e<0: underflow=1, Y=8'h00 (flush).
  - Otherwise: Y={sign_Y, e[2:0], mant_Y}.
- DONE: out_valid=1. Y and the flags are held stable until out_valid&&out_ready, then return to IDLE with out_valid=0 in the next cycle.
- Latency: handshake in cycle 0 -> out_valid asserted in cycle 4.
- Throughput: one operation per 5 cycles minimum; no overlap.
- in_valid while not in IDLE is ignored (in_ready=0); operands are not re-sampled.
- dp_* outputs remain at the last registered values outside ALIGN/CAPTURE.

Optional Feature:
- Macro FP_ADDSUB_SAT_EN, affecting overflow handling only.
- Defined: overflow -> Y={sign_Y, 3'b111, 4'hF} (max magnitude, sign kept), overflow=1.
- Undefined: overflow -> Y={sign_Y, e[2:0], mant_Y} (exponent wraps), overflow=1.
- Underflow behaviour is identical in both builds.

Decomposition:
- Shared package fp8_pkg:
  - EXP_W, MANT_W
  - field-slice constants (SIGN_BIT=7, EXP_MSB=6, EXP_LSB=4)
  - norm-sign encodings NORM_NONE=2'b00, NORM_ADD=2'b01, NORM_SUB=2'b10
  - FSM state enum
- One natural sub-module: fp_exp_norm, the combinational NORM-stage exponent adjust. Inputs big_exp, norm, norm_sign, zero, sign_Y, mant_Y. Outputs Y, overflow, underflow.

Test Plan:
- A=8'h32, B=8'h12, funct=0: dp_exp_diff=4'b0010 during ALIGN. Stub returns sign 01, norm 1, mant 4'h4, sign 0 -> Y=8'h44, flags 0, out_valid in cycle 4.
- A=8'h15, B=8'h35, funct=0: dp_exp_diff=4'b1110 and big_exp=3. Stub returns sign 00, mant 4'h6, sign 0 -> Y=8'h36.
- A=8'h25, B=8'h25, funct=1: stub zero=1 -> Y=8'h00, overflow=0, underflow=0.
- Overflow case (A=8'h7F, B=8'h7F, funct=0): big_exp=7, stub sign 01 norm 1 -> overflow=1. Y=8'h7F with FP_ADDSUB_SAT_EN; Y=8'h0{mant_Y} without it.
- Underflow case (A=8'h90, B=8'h1F): big_exp=1, stub sign 10 norm 3 -> underflow=1, Y=8'h00.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: Y stable, in_ready=0, new in_valid ignored.
  - Assert rst in CAPTURE: next edge shows out_valid=0, in_ready=1, Y=8'h00.
